// File: rtl/hazard_pkg.sv
// Shared defaults and the pipeline-entry record for the hazard tracker.
package hazard_pkg;
    localparam int DEF_STAGES = 3;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_T_W    = 4;

    // All-ones Tuse marks an operand the instruction never reads.
    localparam logic [DEF_T_W-1:0] TUSE_NONE = '1;

    typedef struct packed {
        logic                  vld;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_T_W-1:0]    tnew;
    } hz_entry_t;
endpackage

// File: rtl/hazard_tracker_if.sv
// D-stage request lines in, stall/forward decisions out.
interface hazard_tracker_if
    import hazard_pkg::*;
#(
    parameter int STAGES = DEF_STAGES,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int T_W    = DEF_T_W
) ();
    localparam int SEL_W = $clog2(STAGES + 1);

    logic              id_valid;
    logic [ADDR_W-1:0] id_rs_addr;
    logic [ADDR_W-1:0] id_rt_addr;
    logic [T_W-1:0]    id_rs_use;
    logic [T_W-1:0]    id_rt_use;
    logic [ADDR_W-1:0] id_dst_addr;
    logic [T_W-1:0]    id_dst_save;
    logic              flush;
    logic              stall;
    logic [SEL_W-1:0]  fwd_rs_sel;
    logic [SEL_W-1:0]  fwd_rt_sel;
    logic [15:0]       stall_cnt;

    modport master (
        output id_valid, id_rs_addr, id_rt_addr, id_rs_use, id_rt_use,
               id_dst_addr, id_dst_save, flush,
        input  stall, fwd_rs_sel, fwd_rt_sel, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs_addr, id_rt_addr, id_rs_use, id_rt_use,
               id_dst_addr, id_dst_save, flush,
        output stall, fwd_rs_sel, fwd_rt_sel, stall_cnt
    );
endinterface

// File: rtl/hazard_stage.sv
// One in-flight entry; non-first stages age the incoming tnew by one cycle.
module hazard_stage
    import hazard_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int T_W    = DEF_T_W,
    parameter bit DEC    = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vld_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [T_W-1:0]    tnew_i,
    output logic              vld_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [T_W-1:0]    tnew_o
);
    logic              vld_q;
    logic [ADDR_W-1:0] addr_q;
    logic [T_W-1:0]    tnew_q, tnew_d;

    always_comb begin
        tnew_d = tnew_i;
        if (DEC && tnew_i != '0) tnew_d = tnew_i - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q  <= 1'b0;
            addr_q <= '0;
            tnew_q <= '0;
        end else begin
            vld_q  <= vld_i;
            addr_q <= addr_i;
            tnew_q <= tnew_d;
        end
    end

    assign vld_o  = vld_q;
    assign addr_o = addr_q;
    assign tnew_o = tnew_q;
endmodule

// File: rtl/hazard_tracker.sv
// Tnew/Tuse hazard unit: tracks writers after D, decides stall and bypass source.
module hazard_tracker
    import hazard_pkg::*;
#(
    parameter int STAGES = DEF_STAGES,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int T_W    = DEF_T_W
) (
    input logic       clk,
    input logic       reset,
    hazard_tracker_if.slave hif
);
    localparam int SEL_W = $clog2(STAGES + 1);
    localparam logic [T_W-1:0] USE_NONE = {T_W{1'b1}};

    logic [STAGES:1]             in_vld, e_vld;
    logic [STAGES:1][ADDR_W-1:0] in_addr, e_addr;
    logic [STAGES:1][T_W-1:0]    in_tnew, e_tnew;

    logic             stall;
    logic             rs_ok, rt_ok, rs_stl, rt_stl;
    logic [SEL_W-1:0] rs_sel, rt_sel;
    logic [15:0]      stall_cnt_q;

    for (genvar k = 1; k <= STAGES; k++) begin : g_stage
        hazard_stage #(.ADDR_W(ADDR_W), .T_W(T_W), .DEC(k > 1)) u_stage (
            .clk    (clk),
            .reset  (reset),
            .vld_i  (in_vld[k]),
            .addr_i (in_addr[k]),
            .tnew_i (in_tnew[k]),
            .vld_o  (e_vld[k]),
            .addr_o (e_addr[k]),
            .tnew_o (e_tnew[k])
        );
    end

    always_comb begin
        in_vld[1]  = hif.id_valid & ~stall & ~hif.flush;
        in_addr[1] = hif.id_dst_addr;
        in_tnew[1] = hif.id_dst_save;
        for (int k = 2; k <= STAGES; k++) begin
            in_vld[k]  = e_vld[k-1];
            in_addr[k] = e_addr[k-1];
            in_tnew[k] = e_tnew[k-1];
        end
    end

    // Walk oldest to youngest so the youngest match wins.
    always_comb begin
        rs_stl = 1'b0;
        rt_stl = 1'b0;
        rs_sel = '0;
        rt_sel = '0;
        for (int k = STAGES; k >= 1; k--) begin
            if (e_vld[k] && e_addr[k] == hif.id_rs_addr) begin
                rs_stl = e_tnew[k] > hif.id_rs_use;
                rs_sel = (e_tnew[k] == '0) ? SEL_W'(k) : '0;
            end
            if (e_vld[k] && e_addr[k] == hif.id_rt_addr) begin
                rt_stl = e_tnew[k] > hif.id_rt_use;
                rt_sel = (e_tnew[k] == '0) ? SEL_W'(k) : '0;
            end
        end
        rs_ok = (hif.id_rs_addr != '0) && (hif.id_rs_use != USE_NONE);
        rt_ok = (hif.id_rt_addr != '0) && (hif.id_rt_use != USE_NONE);
        stall = ~reset & hif.id_valid & ((rs_ok & rs_stl) | (rt_ok & rt_stl));
    end

    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt_q <= '0;
        else if (stall && stall_cnt_q != 16'hFFFF)
            stall_cnt_q <= stall_cnt_q + 16'd1;
    end

    assign hif.stall      = stall;
    assign hif.fwd_rs_sel = (reset || !rs_ok) ? '0 : rs_sel;
    assign hif.fwd_rt_sel = (reset || !rt_ok) ? '0 : rt_sel;
    assign hif.stall_cnt  = stall_cnt_q;
endmodule

// File: tb/tb_hazard_tracker.sv
// Randomized + directed scoreboard bench for hazard_tracker against a queue-based pipeline model.
module tb_hazard_tracker;
    import hazard_pkg::*;

    localparam int STAGES = 5;
    localparam int ADDR_W = 5;
    localparam int T_W    = 4;
    localparam int NONE   = (1 << T_W) - 1;

    typedef struct { int stall; int rs; int rt; int cnt; int cyc; } exp_t;
    typedef struct { bit v; int addr; int save; } ment_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    hazard_tracker_if #(.STAGES(STAGES), .ADDR_W(ADDR_W), .T_W(T_W)) hif ();

    hazard_tracker #(.STAGES(STAGES), .ADDR_W(ADDR_W), .T_W(T_W)) dut (
        .clk   (clk),
        .reset (reset),
        .hif   (hif)
    );

    exp_t  sb[$];
    ment_t pipe[$];
    int    mcnt = 0;
    int    checks = 0;
    int    errors = 0;
    int    ncyc = 0;

    // Model: pipe[i] is the instruction i+1 stages past D; its tnew is save aged by i cycles.
    function automatic void lookup(input int a, input int u, output bit st, output int sel);
        st = 0;
        sel = 0;
        if (a == 0 || u == NONE) return;
        for (int i = 0; i < pipe.size(); i++) begin
            if (pipe[i].v && pipe[i].addr == a) begin
                int tn;
                tn  = (pipe[i].save > i) ? pipe[i].save - i : 0;
                st  = tn > u;
                sel = (tn == 0) ? i + 1 : 0;
                return;
            end
        end
    endfunction

    task automatic cyc(input bit rst, input bit v, input int rs, input int rsu,
                       input int rt, input int rtu, input int dst, input int sav, input bit fl);
        bit   s1, s2, stl;
        int   l1, l2;
        exp_t e;
        @(posedge clk);
        #1;
        reset           = rst;
        hif.id_valid    = v;
        hif.id_rs_addr  = ADDR_W'(rs);
        hif.id_rs_use   = T_W'(rsu);
        hif.id_rt_addr  = ADDR_W'(rt);
        hif.id_rt_use   = T_W'(rtu);
        hif.id_dst_addr = ADDR_W'(dst);
        hif.id_dst_save = T_W'(sav);
        hif.flush       = fl;
        lookup(rs, rsu, s1, l1);
        lookup(rt, rtu, s2, l2);
        stl   = !rst && v && (s1 || s2);
        e.stall = stl;
        e.rs  = rst ? 0 : l1;
        e.rt  = rst ? 0 : l2;
        e.cnt = mcnt;
        e.cyc = ncyc;
        sb.push_back(e);
        ncyc++;
        if (rst) begin
            pipe.delete();
            mcnt = 0;
        end else begin
            if (stl && mcnt < 65535) mcnt++;
            pipe.push_front('{v && !stl && !fl, dst, sav});
            if (pipe.size() > STAGES) void'(pipe.pop_back());
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checks++;
                if (int'(hif.stall) != e.stall) begin
                    errors++;
                    $display("FAIL stall cyc=%0d got=%0d exp=%0d", e.cyc, hif.stall, e.stall);
                end
                checks++;
                if (int'(hif.fwd_rs_sel) != e.rs) begin
                    errors++;
                    $display("FAIL fwd_rs_sel cyc=%0d got=%0d exp=%0d", e.cyc, hif.fwd_rs_sel, e.rs);
                end
                checks++;
                if (int'(hif.fwd_rt_sel) != e.rt) begin
                    errors++;
                    $display("FAIL fwd_rt_sel cyc=%0d got=%0d exp=%0d", e.cyc, hif.fwd_rt_sel, e.rt);
                end
                checks++;
                if (int'(hif.stall_cnt) != e.cnt) begin
                    errors++;
                    $display("FAIL stall_cnt cyc=%0d got=%0d exp=%0d", e.cyc, hif.stall_cnt, e.cnt);
                end
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout exp finish");
        $fatal(1, "timeout");
    end

    initial begin : driver
        hif.id_valid = 1'b0; hif.id_rs_addr = '0; hif.id_rt_addr = '0;
        hif.id_rs_use = '1; hif.id_rt_use = '1; hif.id_dst_addr = '0;
        hif.id_dst_save = '0; hif.flush = 1'b0;

        // Reset with live D inputs that would otherwise look hazardous
        repeat (2) cyc(1, 1, 8, 0, 9, 0, 8, 3, 0);
        cyc(0, 0, 0, NONE, 0, NONE, 0, 0, 0);

        // lw $8 (save 2) then reader rs=$8 use 1 held in D
        cyc(0, 1, 0, NONE, 0, NONE, 8, 2, 0);
        repeat (4) cyc(0, 1, 8, 1, 0, NONE, 11, 1, 0);
        repeat (STAGES) cyc(0, 0, 0, NONE, 0, NONE, 0, 0, 0);

        // addu $9 (save 1) then beq on $9 with use 0
        cyc(0, 1, 0, NONE, 0, NONE, 9, 1, 0);
        repeat (3) cyc(0, 1, 9, 0, 0, NONE, 0, 0, 0);

        // Two writers to $10 then a reader on rt: youngest wins
        cyc(0, 1, 0, NONE, 0, NONE, 10, 0, 0);
        cyc(0, 1, 0, NONE, 0, NONE, 10, 0, 0);
        cyc(0, 1, 0, NONE, 10, 1, 0, 0, 0);

        // Writer to $0, and unused-operand reader
        cyc(0, 1, 0, NONE, 0, NONE, 0, 3, 0);
        cyc(0, 1, 0, 0, 0, 0, 12, 3, 0);
        cyc(0, 1, 12, NONE, 0, NONE, 0, 0, 0);
        cyc(0, 1, 12, 0, 12, NONE, 0, 0, 0);

        // Flush kills the D writer
        cyc(0, 1, 0, NONE, 0, NONE, 13, 0, 1);
        cyc(0, 1, 13, 0, 0, NONE, 0, 0, 0);

        // Reset mid-stall: lw in E, reader stalling, then reset
        cyc(0, 1, 0, NONE, 0, NONE, 8, 2, 0);
        cyc(0, 1, 8, 0, 0, NONE, 0, 0, 0);
        cyc(1, 1, 8, 0, 0, NONE, 0, 0, 0);
        repeat (2) cyc(0, 1, 8, 0, 0, NONE, 0, 0, 0);

        for (int n = 0; n < 2000; n++) begin
            int ru, tu;
            ru = ($urandom_range(0, 4) == 0) ? NONE : int'($urandom_range(0, 3));
            tu = ($urandom_range(0, 4) == 0) ? NONE : int'($urandom_range(0, 3));
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0,
                $urandom_range(0, 3), ru, $urandom_range(0, 3), tu,
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 9) == 0);
        end

        // Self-dependent long-latency writer keeps stall high most cycles
        for (int n = 0; n < 79500; n++) cyc(0, 1, 1, 0, 0, NONE, 1, 15, 0);
        // Stall together with flush: bubbles only, counter stays saturated
        repeat (12) cyc(0, 1, 1, 0, 0, NONE, 1, 15, 1);
        repeat (3) cyc(0, 1, 1, 0, 0, NONE, 1, 15, 0);
        cyc(1, 0, 0, NONE, 0, NONE, 0, 0, 0);
        cyc(0, 0, 0, NONE, 0, NONE, 0, 0, 0);

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d pending exp=0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
